// File: rtl/mul_pkg.sv
// Sizing helpers shared by the partial-product tree and its levels.
// Latency: none (constants and constant functions only).
// Backpressure: none; the optional result counter is gated by MUL_TREE_CNT_EN in the top.
package mul_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    function automatic int node_w(input int pp_w, input int l);
        return pp_w + (1 << l);
    endfunction

    function automatic int nodes(input int n_pp, input int l);
        return (n_pp + (1 << l) - 1) >> l;
    endfunction

    // A node can never exceed the full product width, so deep levels are clipped there.
    function automatic int lvl_w(input int pp_w, input int n_pp, input int l);
        return (node_w(pp_w, l) < pp_w + n_pp) ? node_w(pp_w, l) : pp_w + n_pp;
    endfunction

    localparam int PP_W_DEF = 24;
    localparam int N_PP_DEF = 24;
    localparam int LEVELS   = clog2(N_PP_DEF);
    localparam int OUT_W    = PP_W_DEF + N_PP_DEF;

endpackage

// File: rtl/mul_tree_level.sv
// One tree level: pairwise shift-and-add of nodes with 4-bit-slice CLA adders, then a register.
// Latency: 1 cycle.
// Backpressure: data and valid load only when adv=1, otherwise hold.
module mul_tree_level
    import mul_pkg::*;
#(
    parameter int PP_W = 24,
    parameter int N_PP = 24,
    parameter int LVL  = 0,
    parameter int N_IN = 24
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    adv,
    input  logic                                                    in_vld,
    input  logic [N_IN*lvl_w(PP_W, N_PP, LVL)-1:0]                  in_dat,
    output logic                                                    out_vld,
    output logic [((N_IN+1)/2)*lvl_w(PP_W, N_PP, LVL+1)-1:0]        out_dat
);
    localparam int IW    = lvl_w(PP_W, N_PP, LVL);
    localparam int OW    = lvl_w(PP_W, N_PP, LVL + 1);
    localparam int N_OUT = (N_IN + 1) / 2;
    localparam int ADD_W = ((OW + 3) / 4) * 4;
    localparam int PAD_W = 2 * N_OUT * IW;
    localparam int SH    = 1 << LVL;

    function automatic logic [ADD_W-1:0] cla_add(input logic [ADD_W-1:0] a,
                                                 input logic [ADD_W-1:0] b);
        logic [ADD_W-1:0] s;
        logic [3:0]       g, p, c;
        logic             ci;
        s  = '0;
        ci = 1'b0;
        for (int k = 0; k < ADD_W / 4; k++) begin
            g    = a[4*k +: 4] & b[4*k +: 4];
            p    = a[4*k +: 4] ^ b[4*k +: 4];
            c[0] = ci;
            c[1] = g[0] | (p[0] & ci);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
            ci   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (&p & ci);
            s[4*k +: 4] = p ^ c;
        end
        return s;
    endfunction

    // Odd node count: the zero padding becomes the missing addend.
    logic [PAD_W-1:0]     in_pad;
    logic [N_OUT*OW-1:0]  add_res;
    logic [N_OUT*OW-1:0]  dat_d, dat_q;
    logic                 vld_d, vld_q;

    assign in_pad = PAD_W'(in_dat);

    always_comb begin
        add_res = '0;
        for (int j = 0; j < N_OUT; j++) begin
            add_res[j*OW +: OW] = OW'(cla_add(ADD_W'(in_pad[2*j*IW +: IW]),
                                              ADD_W'(in_pad[(2*j+1)*IW +: IW]) << SH));
        end
        dat_d = adv ? add_res : dat_q;
        vld_d = adv ? in_vld  : vld_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign out_dat = dat_q;
    assign out_vld = vld_q;

endmodule

// File: rtl/mul_pp_tree_pipe.sv
// Pipelined partial-product reduction tree: out_sum = sum of pp[i] << i; MUL_TREE_CNT_EN adds res_cnt.
// Latency: clog2(N_PP) cycles, one product per cycle.
// Backpressure: global stall, in_ready = out_ready | ~out_valid freezes every level.
module mul_pp_tree_pipe
    import mul_pkg::*;
#(
    parameter int PP_W = 24,
    parameter int N_PP = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_PP*PP_W-1:0]   in_pp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PP_W+N_PP-1:0]   out_sum,
    output logic [31:0]            res_cnt
);
    localparam int N_LVL = clog2(N_PP);
    localparam int W0    = lvl_w(PP_W, N_PP, 0);

    logic                 adv;
    logic [N_PP*W0-1:0]   pp0_dat;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    always_comb begin
        pp0_dat = '0;
        for (int i = 0; i < N_PP; i++) begin
            pp0_dat[i*W0 +: W0] = W0'(in_pp[i*PP_W +: PP_W]);
        end
    end

    for (genvar g = 0; g < N_LVL; g++) begin : g_lvl
        localparam int N_IN = nodes(N_PP, g);
        localparam int IW   = lvl_w(PP_W, N_PP, g);
        localparam int N_O  = nodes(N_PP, g + 1);
        localparam int OW   = lvl_w(PP_W, N_PP, g + 1);

        logic [N_IN*IW-1:0] src_dat;
        logic               src_vld;
        logic [N_O*OW-1:0]  dat;
        logic               vld;

        if (g == 0) begin : g_src
            assign src_dat = pp0_dat;
            assign src_vld = in_valid & in_ready;
        end else begin : g_src
            assign src_dat = g_lvl[g-1].dat;
            assign src_vld = g_lvl[g-1].vld;
        end

        mul_tree_level #(
            .PP_W (PP_W),
            .N_PP (N_PP),
            .LVL  (g),
            .N_IN (N_IN)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .in_vld  (src_vld),
            .in_dat  (src_dat),
            .out_vld (vld),
            .out_dat (dat)
        );
    end

    assign out_valid = g_lvl[N_LVL-1].vld;
    assign out_sum   = g_lvl[N_LVL-1].dat;

`ifdef MUL_TREE_CNT_EN
    logic [31:0] res_cnt_d, res_cnt_q;

    always_comb begin
        res_cnt_d = res_cnt_q;
        if (out_valid & out_ready) res_cnt_d = res_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) res_cnt_q <= '0;
        else        res_cnt_q <= res_cnt_d;
    end

    assign res_cnt = res_cnt_q;
`else
    assign res_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_pp_tree_pipe.sv
// Randomised bench for mul_pp_tree_pipe: products A*B against a plain-arithmetic reference.
// Latency checked at 5 cycles; stalls, mid-flight reset and MUL_TREE_CNT_EN counter covered.
// Backpressure exercised through out_ready stalls and random in_valid gaps.
module tb_mul_pp_tree_pipe;
    localparam int PP_W   = 24;
    localparam int N_PP   = 24;
    localparam int OUT_W  = PP_W + N_PP;
    localparam int PP_TOT = PP_W * N_PP;
    localparam int LAT    = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PP_TOT-1:0] in_pp;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_sum;
    logic [31:0]       res_cnt;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    mul_pp_tree_pipe #(.PP_W(PP_W), .N_PP(N_PP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pp     (in_pp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .res_cnt   (res_cnt)
    );

    function automatic logic [PP_TOT-1:0] make_pp(input logic [PP_W-1:0] a, input logic [PP_W-1:0] b);
        logic [PP_TOT-1:0] v;
        v = '0;
        for (int i = 0; i < N_PP; i++) if (b[i]) v[i*PP_W +: PP_W] = a;
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] prod(input logic [PP_W-1:0] a, input logic [PP_W-1:0] b);
        logic [OUT_W-1:0] wa, wb;
        wa = OUT_W'(a);
        wb = OUT_W'(b);
        return wa * wb;
    endfunction

    // Drive one cycle's inputs, sample the handshakes just before the next edge, then step past it.
    task automatic tick(input logic iv, input logic [PP_TOT-1:0] pp, input logic ordy,
                        output logic ia, output logic oa, output logic [OUT_W-1:0] s);
        in_valid  = iv;
        in_pp     = pp;
        out_ready = ordy;
        #1;
        ia = in_valid & in_ready;
        oa = out_valid & out_ready;
        s  = out_sum;
        if (oa && rst_n) hs_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pp     = '0;
        repeat (n) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        hs_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pp     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
        checks++;
        if (res_cnt !== 32'd0) begin errors++; $display("FAIL reset_res_cnt got=%0d exp=0", res_cnt); end
        rst_n  = 1'b1;
        hs_cnt = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        logic [PP_W-1:0]  a;
        logic [OUT_W-1:0] s, got;
        logic             ia, oa, acc0;
        int               first;
        a     = 24'hFFFFFF;
        first = -1;
        got   = '0;
        acc0  = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick(t == 0, make_pp(a, a), 1'b1, ia, oa, s);
            if (t == 0) acc0 = ia;
            if (oa && first < 0) begin first = t; got = s; end
        end
        checks++;
        if (acc0 !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", acc0); end
        checks++;
        if (first != LAT) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", first, LAT); end
        checks++;
        if (got !== 48'hFFFFFE000001) begin errors++; $display("FAIL single_sum got=%h exp=fffffe000001", got); end
    endtask

    task automatic test_back_to_back();
        logic [PP_W-1:0]  op_a [3];
        logic [PP_W-1:0]  op_b [3];
        logic [OUT_W-1:0] exp_v [3];
        logic [OUT_W-1:0] vals [3];
        int               idx [3];
        logic [OUT_W-1:0] s;
        logic             ia, oa;
        int               n;
        op_a  = '{24'd3, 24'h800000, 24'd0};
        op_b  = '{24'd5, 24'd2, 24'h123456};
        exp_v = '{48'd15, 48'h1000000, 48'd0};
        n = 0;
        for (int k = 0; k < 3; k++) begin vals[k] = '1; idx[k] = -1; end
        for (int t = 0; t < 15; t++) begin
            tick(t < 3, make_pp(op_a[t % 3], op_b[t % 3]), 1'b1, ia, oa, s);
            if (oa) begin
                if (n < 3) begin vals[n] = s; idx[n] = t; end
                n++;
            end
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", n); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vals[k] !== exp_v[k]) begin errors++; $display("FAIL b2b_value[%0d] got=%h exp=%h", k, vals[k], exp_v[k]); end
            checks++;
            if (idx[k] != LAT + k) begin errors++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", k, idx[k], LAT + k); end
        end
    endtask

    task automatic test_stall();
        logic [OUT_W-1:0] exp_q [$];
        logic [OUT_W-1:0] s, held, want;
        logic [PP_W-1:0]  ca, cb;
        logic             ia, oa, stall_bad;
        int               fed, got;
        fed = 0; got = 0; stall_bad = 1'b0;
        ca = 24'($urandom); cb = 24'($urandom);
        for (int t = 0; t < LAT; t++) begin
            tick(1'b1, make_pp(ca, cb), 1'b1, ia, oa, s);
            if (ia) begin exp_q.push_back(prod(ca, cb)); fed++; ca = 24'($urandom); cb = 24'($urandom); end
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_full got=%b exp=1", out_valid); end
        held = out_sum;
        for (int t = 0; t < 3; t++) begin
            tick(1'b1, make_pp(ca, cb), 1'b0, ia, oa, s);
            if (ia || s !== held || out_sum !== held) stall_bad = 1'b1;
        end
        checks++;
        if (stall_bad) begin errors++; $display("FAIL stall_hold got=%h exp=%h in_ready=%b", out_sum, held, in_ready); end
        for (int t = 0; t < 30; t++) begin
            tick(fed < 8, make_pp(ca, cb), 1'b1, ia, oa, s);
            if (ia) begin exp_q.push_back(prod(ca, cb)); fed++; ca = 24'($urandom); cb = 24'($urandom); end
            if (oa) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (s !== want) begin errors++; $display("FAIL stall_order[%0d] got=%h exp=%h", got, s, want); end
                got++;
            end
        end
        checks++;
        if (got != 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL stall_count got=%0d exp=8 left=%0d", got, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [OUT_W-1:0] s, got_v;
        logic [PP_W-1:0]  ca, cb;
        logic             ia, oa;
        int               seen, first;
        for (int t = 0; t < 2; t++) tick(1'b1, make_pp(24'($urandom), 24'($urandom)), 1'b1, ia, oa, s);
        tick(1'b0, '0, 1'b1, ia, oa, s);
        rst_n = 1'b0;
        tick(1'b0, '0, 1'b1, ia, oa, s);
        rst_n  = 1'b1;
        hs_cnt = 0;
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            tick(1'b0, '0, 1'b1, ia, oa, s);
            if (oa) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_ghost got=%0d exp=0", seen); end
        ca = 24'($urandom); cb = 24'($urandom);
        first = -1; got_v = '0;
        for (int t = 0; t < 12; t++) begin
            tick(t == 0, make_pp(ca, cb), 1'b1, ia, oa, s);
            if (oa && first < 0) begin first = t; got_v = s; end
        end
        checks++;
        if (first != LAT) begin errors++; $display("FAIL rstmid_latency got=%0d exp=%0d", first, LAT); end
        checks++;
        if (got_v !== prod(ca, cb)) begin errors++; $display("FAIL rstmid_value got=%h exp=%h", got_v, prod(ca, cb)); end
    endtask

    task automatic test_random();
        logic [OUT_W-1:0] exp_q [$];
        logic [OUT_W-1:0] s, want;
        logic [PP_W-1:0]  ca, cb;
        logic             ia, oa, iv;
        int               fed, got, exp_cnt;
        do_reset(2);
        fed = 0; got = 0;
        ca = 24'($urandom); cb = 24'($urandom);
        for (int t = 0; t < 400 && got < 10; t++) begin
            iv = (fed < 10) && ($urandom_range(0, 3) != 0);
            tick(iv, make_pp(ca, cb), $urandom_range(0, 2) != 0, ia, oa, s);
            if (ia) begin exp_q.push_back(prod(ca, cb)); fed++; ca = 24'($urandom); cb = 24'($urandom); end
            if (oa) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (s !== want) begin errors++; $display("FAIL random_value[%0d] got=%h exp=%h", got, s, want); end
                got++;
            end
        end
        checks++;
        if (got != 10) begin errors++; $display("FAIL random_count got=%0d exp=10", got); end
`ifdef MUL_TREE_CNT_EN
        exp_cnt = hs_cnt;
`else
        exp_cnt = 0;
`endif
        checks++;
        if (res_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL random_res_cnt got=%0d exp=%0d", res_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
